// File: rtl/wb_trace_buf.sv
// Writeback retirement trace capture: FWFT FIFO with drop accounting.
// Never back-pressures the core; overflowing records are counted and lost.
module wb_trace_buf #(
  parameter int DEPTH       = 16,
  parameter bit FILTER_NOWR = 1'b1
) (
  input  logic                       cpu_clk_50M,
  input  logic                       cpu_rst,
  input  logic                       trace_en,
  input  logic                       trace_clr,
  input  logic [31:0]                debug_wb_pc,
  input  logic [3:0]                 debug_wb_rf_wen,
  input  logic [4:0]                 debug_wb_rf_wnum,
  input  logic [31:0]                debug_wb_rf_wdata,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [31:0]                trace_pc,
  output logic [3:0]                 trace_wen,
  output logic [4:0]                 trace_wnum,
  output logic [31:0]                trace_wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [72:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [72:0]   head;
  logic          push_req;
  logic          pop;
  logic          accept;
  logic          drop;

  always_comb begin
    push_req = trace_en & (FILTER_NOWR ? |debug_wb_rf_wen : 1'b1);
    pop      = trace_valid & trace_ready;
    accept   = push_req & ((count != FULL_C) | pop);
    drop     = push_req & ~accept;
  end

  // Stale storage is hidden while empty so the port reads zero after reset.
  assign trace_valid = (count != '0);
  assign head        = trace_valid ? mem[rp] : '0;
  assign trace_pc    = head[72:41];
  assign trace_wen   = head[40:37];
  assign trace_wnum  = head[36:32];
  assign trace_wdata = head[31:0];

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst && accept)
      mem[wp] <= {debug_wb_pc, debug_wb_rf_wen,
                  debug_wb_rf_wnum, debug_wb_rf_wdata};
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (accept) wp <= wp + AW'(1);
      if (pop)    rp <= rp + AW'(1);
      unique case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A drop in the clear cycle is kept so no loss goes unreported.
      if (trace_clr) begin
        overflow <= drop;
        drop_cnt <= drop ? 16'd1 : 16'd0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_buf.sv
// Directed bench for wb_trace_buf.
// Second instance runs with the write filter disabled.
module tb_wb_trace_buf;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        trace_en;
  logic        trace_clr;
  logic [31:0] pc;
  logic [3:0]  wen;
  logic [4:0]  wnum;
  logic [31:0] wdata;
  logic        trace_ready;

  logic        tv;
  logic [31:0] tpc;
  logic [3:0]  twen;
  logic [4:0]  twnum;
  logic [31:0] twdata;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  logic        tv0;
  logic [31:0] tpc0;
  logic [3:0]  twen0;
  logic [4:0]  twnum0;
  logic [31:0] twdata0;
  logic [4:0]  count0;
  logic        overflow0;
  logic [15:0] drop_cnt0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_trace_buf #(.DEPTH(16), .FILTER_NOWR(1'b1)) dut (
    .cpu_clk_50M       (clk),
    .cpu_rst           (cpu_rst),
    .trace_en          (trace_en),
    .trace_clr         (trace_clr),
    .debug_wb_pc       (pc),
    .debug_wb_rf_wen   (wen),
    .debug_wb_rf_wnum  (wnum),
    .debug_wb_rf_wdata (wdata),
    .trace_valid       (tv),
    .trace_ready       (trace_ready),
    .trace_pc          (tpc),
    .trace_wen         (twen),
    .trace_wnum        (twnum),
    .trace_wdata       (twdata),
    .count             (count),
    .overflow          (overflow),
    .drop_cnt          (drop_cnt)
  );

  wb_trace_buf #(.DEPTH(16), .FILTER_NOWR(1'b0)) dut0 (
    .cpu_clk_50M       (clk),
    .cpu_rst           (cpu_rst),
    .trace_en          (trace_en),
    .trace_clr         (trace_clr),
    .debug_wb_pc       (pc),
    .debug_wb_rf_wen   (wen),
    .debug_wb_rf_wnum  (wnum),
    .debug_wb_rf_wdata (wdata),
    .trace_valid       (tv0),
    .trace_ready       (trace_ready),
    .trace_pc          (tpc0),
    .trace_wen         (twen0),
    .trace_wnum        (twnum0),
    .trace_wdata       (twdata0),
    .count             (count0),
    .overflow          (overflow0),
    .drop_cnt          (drop_cnt0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    trace_en    = 1'b0;
    trace_clr   = 1'b0;
    trace_ready = 1'b0;
    wen         = 4'h0;
  endtask

  task automatic set_rec(input logic [31:0] p, input logic [3:0] w);
    trace_en = 1'b1;
    pc       = p;
    wen      = w;
    wnum     = p[4:0];
    wdata    = ~p;
  endtask

  task automatic do_reset();
    idle();
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      set_rec(32'(i), 4'h1);
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    set_rec(32'h1111_2222, 4'hF);
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    idle();
    checks++;
    if (count !== 5'd0) begin
      errors++; $display("FAIL rst_count got=%0d exp=0", count);
    end
    checks++;
    if (tv !== 1'b0) begin
      errors++; $display("FAIL rst_valid got=%b exp=0", tv);
    end
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_drop got=%b/%0d exp=0/0", overflow, drop_cnt);
    end
    checks++;
    if (tpc !== 32'd0 || twdata !== 32'd0 || twnum !== 5'd0) begin
      errors++; $display("FAIL rst_head got=%h/%h exp=0/0", tpc, twdata);
    end
  endtask

  task automatic test_single();
    do_reset();
    trace_en = 1'b1;
    pc = 32'hBFC0_0000; wen = 4'h1; wnum = 5'd8; wdata = 32'h1234_5678;
    tick();
    idle();
    checks++;
    if (tv !== 1'b1 || count !== 5'd1) begin
      errors++; $display("FAIL single_vld got=%b/%0d exp=1/1", tv, count);
    end
    checks++;
    if (tpc !== 32'hBFC0_0000 || twnum !== 5'd8 ||
        twdata !== 32'h1234_5678 || twen !== 4'h1) begin
      errors++;
      $display("FAIL single_rec got=%h/%0d/%h exp=bfc00000/8/12345678",
               tpc, twnum, twdata);
    end
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    checks++;
    if (tv !== 1'b0 || count !== 5'd0) begin
      errors++; $display("FAIL single_pop got=%b/%0d exp=0/0", tv, count);
    end
  endtask

  task automatic test_filter();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_rec(32'h0000_0050 + 32'(i), 4'h0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_rec(32'h0000_0100 + 32'(4 * i), 4'h1);
      tick();
    end
    idle();
    checks++;
    if (count !== 5'd3) begin
      errors++; $display("FAIL filt_count got=%0d exp=3", count);
    end
    checks++;
    if (count0 !== 5'd8) begin
      errors++; $display("FAIL nofilt_count got=%0d exp=8", count0);
    end
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h0000_0100 + 32'(4 * i);
      checks++;
      if (tv !== 1'b1 || tpc !== exp_pc) begin
        errors++;
        $display("FAIL filt_order got=%h exp=%h", tpc, exp_pc);
      end
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_rec(32'(i), 4'h2);
      tick();
    end
    idle();
    checks++;
    if (count !== 5'd16) begin
      errors++; $display("FAIL ovf_count got=%0d exp=16", count);
    end
    checks++;
    if (overflow !== 1'b1 || drop_cnt !== 16'd4) begin
      errors++;
      $display("FAIL ovf_drop got=%b/%0d exp=1/4", overflow, drop_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (tv !== 1'b1 || tpc !== 32'(i)) begin
        errors++; $display("FAIL ovf_drain got=%0d exp=%0d", tpc, i);
      end
      trace_ready = 1'b1;
      tick();
      trace_ready = 1'b0;
    end
    checks++;
    if (tv !== 1'b0 || count !== 5'd0) begin
      errors++; $display("FAIL ovf_empty got=%b/%0d exp=0/0", tv, count);
    end
    trace_clr = 1'b1;
    tick();
    trace_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL ovf_clr got=%b/%0d exp=0/0", overflow, drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill16();
    trace_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tpc !== 32'(i)) begin
        errors++; $display("FAIL b2b_head got=%0d exp=%0d", tpc, i);
      end
      set_rec(32'(16 + i), 4'h4);
      tick();
      checks++;
      if (count !== 5'd16) begin
        errors++; $display("FAIL b2b_count got=%0d exp=16", count);
      end
    end
    idle();
    checks++;
    if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drop got=%b/%0d exp=0/0", overflow, drop_cnt);
    end
    checks++;
    if (tpc !== 32'd10) begin
      errors++; $display("FAIL b2b_next got=%0d exp=10", tpc);
    end
  endtask

  task automatic test_clr_collision();
    do_reset();
    fill16();
    for (int i = 0; i < 5; i++) begin
      set_rec(32'h0000_0900, 4'h1);
      tick();
    end
    checks++;
    if (drop_cnt !== 16'd5) begin
      errors++; $display("FAIL coll_pre got=%0d exp=5", drop_cnt);
    end
    trace_clr = 1'b1;
    tick();
    trace_clr = 1'b0;
    idle();
    checks++;
    if (drop_cnt !== 16'd1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL coll_win got=%b/%0d exp=1/1", overflow, drop_cnt);
    end
    trace_clr = 1'b1;
    tick();
    trace_clr = 1'b0;
    set_rec(32'h0000_0a00, 4'h1);
    for (int i = 0; i < 65534; i++) tick();
    checks++;
    if (drop_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL sat_pre got=%h exp=fffe", drop_cnt);
    end
    for (int i = 0; i < 3; i++) tick();
    idle();
    checks++;
    if (drop_cnt !== 16'hFFFF || overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold got=%b/%h exp=1/ffff", overflow, drop_cnt);
    end
    checks++;
    if (count !== 5'd16 || tpc !== 32'd0) begin
      errors++; $display("FAIL sat_fifo got=%0d/%0d exp=16/0", count, tpc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_rec(32'h0000_0200 + 32'(i), 4'h1);
      tick();
    end
    checks++;
    if (count !== 5'd7) begin
      errors++; $display("FAIL mid_pre got=%0d exp=7", count);
    end
    set_rec(32'h0000_DEAD, 4'h1);
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    idle();
    checks++;
    if (count !== 5'd0 || tv !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got=%0d/%b/%b exp=0/0/0", count, tv, overflow);
    end
    set_rec(32'h0000_0300, 4'h1);
    tick();
    idle();
    checks++;
    if (count !== 5'd1 || tv !== 1'b1 || tpc !== 32'h0000_0300) begin
      errors++;
      $display("FAIL mid_first got=%0d/%h exp=1/300", count, tpc);
    end
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    checks++;
    if (tv !== 1'b0) begin
      errors++; $display("FAIL mid_alone got=%b exp=0", tv);
    end
  endtask

  initial begin
    cpu_rst = 1'b0;
    pc = '0; wnum = '0; wdata = '0;
    idle();
    #2;
    test_reset();
    test_single();
    test_filter();
    test_overflow();
    test_back_to_back();
    test_clr_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_trace_buf.md
Name: wb_trace_buf

Overview:
- Captures the CPU's writeback-retirement debug stream (debug_wb_pc / rf_wen / rf_wnum / rf_wdata) into a first-word-fall-through FIFO.
- Presents captured records on a valid/ready trace port for a trace drain (UART dumper, compare engine).
- Sits directly downstream of the MiniMIPS32 core in the SoC top and never back-pressures the core: records are dropped when full and the drops are counted.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, >= 2.
- FILTER_NOWR, 1, when 1 capture only records with debug_wb_rf_wen != 0; when 0 capture every cycle with trace_en=1.

Ports:
- cpu_clk_50M  in  1  clock; all state updates on its rising edge.
- cpu_rst  in  1  synchronous reset, active-high.
- trace_en  in  1  capture enable.
- trace_clr  in  1  one-cycle pulse; clears overflow and drop_cnt; FIFO contents are kept.
- debug_wb_pc  in  32  retiring PC.
- debug_wb_rf_wen  in  4  regfile write enable.
- debug_wb_rf_wnum  in  5  destination register.
- debug_wb_rf_wdata  in  32  write data.
- trace_valid  out  1  head record available.
- trace_ready  in  1  drain accepts the head record.
- trace_pc  out  32  head record PC.
- trace_wen  out  4  head record wen.
- trace_wnum  out  5  head record wnum.
- trace_wdata  out  32  head record wdata.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one record dropped.
- drop_cnt  out  16  dropped-record count, saturating.

Behaviour:
- Record width is 73 bits: {pc, wen, wnum, wdata}. Storage is a DEPTH x 73 array with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Occupancy is tracked in count.
- push_req = trace_en & (FILTER_NOWR ? |debug_wb_rf_wen : 1).
- pop = trace_valid & trace_ready.
- trace_valid = (count != 0). trace_* outputs always reflect the entry at the read pointer.
- Latency: a record pushed at edge N is visible on trace_* with trace_valid=1 after edge N. There is no same-cycle bypass.
- Push acceptance: accept = push_req & ((count < DEPTH) | pop). The write pointer advances on accept; the read pointer advances on pop.
- count update per edge:
  - +1 on accept without pop;
  - -1 on pop without accept;
  - unchanged when both or neither occur.
- Full with pop and push_req in the same cycle: both happen, count stays DEPTH, and no drop occurs.
- Empty with push_req and trace_ready=1: there is no pop that cycle, because trace_valid=0. The record appears next cycle.
- Drop = push_req & ~accept. On a drop:
  - overflow <= 1;
  - drop_cnt <= drop_cnt + 1, saturating at 16'hFFFF (no wrap).
- trace_clr:
  - overflow <= drop;
  - drop_cnt <= drop ? 16'd1 : 16'd0.
  - A drop in the same cycle therefore wins over clear.
- trace_ready while trace_valid=0 has no effect.
- trace_en=0 suppresses capture only; draining continues.
- Reset, when cpu_rst=1 at an edge:
  - pointers=0, count=0, overflow=0, drop_cnt=0;
  - trace_valid=0;
  - trace_* read as 0, with storage gated to zero while count=0.
  - Inputs are ignored on the reset edge.
- Reset mid-operation discards all buffered records. The first record after reset deasserts is accepted normally.
- Capture never stalls the core; the block has no path back to the core.

Test Plan:
- Single record: reset, then push pc=32'hBFC0_0000, wen=4'h1, wnum=5'd8, wdata=32'h1234_5678 with trace_ready=0 -> next cycle trace_valid=1, trace_pc=BFC00000, trace_wnum=8, trace_wdata=12345678, count=1. Raise trace_ready -> count=0 and trace_valid=0 the following cycle.
- Filter: FILTER_NOWR=1, 5 cycles of wen=0 followed by 3 cycles of wen=1 with pc=0x100/0x104/0x108, trace_ready=0 -> count=3, FIFO order 0x100, 0x104, 0x108. With FILTER_NOWR=0, the same stimulus -> count=8.
- Overflow: DEPTH=16, trace_ready=0, 20 consecutive pushes of pc=0..19 -> count=16, overflow=1, drop_cnt=4. Draining yields pc 0..15 in order with no 16..19. Then pulse trace_clr -> overflow=0, drop_cnt=0.
- Full plus simultaneous pop/push: fill to 16, then trace_ready=1 and push_req every cycle for 10 cycles -> count stays 16, drop_cnt=0, output order continuous.
- Clear/drop collision: full, trace_ready=0, drop_cnt=5; push_req and trace_clr in the same cycle -> drop_cnt=1, overflow=1. Separately, force drop_cnt=16'hFFFE and cause 3 drops -> drop_cnt=16'hFFFF.
- Reset mid-stream: count=7, assert cpu_rst for 1 cycle while pushing -> count=0, trace_valid=0, overflow=0. The next push appears alone at the head with count=1.
